// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - multi-channel push-button synchroniser, debouncer and press/hold pulse generator
//
// Each channel is independent. The raw input passes through a two-flop
// synchroniser and a counter-based debouncer, which drive a clean level and
// one-cycle press/release pulses. A hold FSM then generates a long-press pulse
// and periodic auto-repeat pulses while the button stays down.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-high reset
//   pb_in      - raw asynchronous button inputs [N]
//   level      - debounced level [N]
//   press      - one-cycle pulse on level rise [N]
//   rel_pulse  - one-cycle pulse on level fall [N]
//   long_press - one-cycle pulse LONG_CYCLES after press [N]
//   repeat_p   - one-cycle pulse every REPEAT_CYCLES after long_press [N]
module button_conditioner #(
    parameter int N             = 4,
    parameter int DB_CYCLES     = 16,
    parameter int LONG_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 250
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] pb_in,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] rel_pulse,
    output logic [N-1:0] long_press,
    output logic [N-1:0] repeat_p
);

    localparam int DB_W     = $clog2(DB_CYCLES + 1);
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
    // With auto-repeat disabled RPT is never entered, so this value is unused.
    localparam logic [HOLD_W-1:0] RPT_LAST  =
        (REPEAT_CYCLES > 0) ? HOLD_W'(REPEAT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        RPT  = 2'd2
    } hold_state_t;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic              s1;
        logic              s2;
        logic              level_r;
        logic [DB_W-1:0]   db_cnt;
        logic              press_r;
        logic              rel_r;
        logic              long_r;
        logic              rep_r;
        hold_state_t       state;
        logic [HOLD_W-1:0] hold_cnt;
        // Set once long_press has fired with auto-repeat disabled: HELD then
        // sits with hold_cnt frozen so the long press fires only once per hold.
        logic              long_done;

        logic flip;
        logic rise;
        logic fall;

        // The level flips on this edge: synchronised input has disagreed for
        // DB_CYCLES consecutive samples.
        assign flip = (s2 != level_r) && (db_cnt == DB_LAST);
        assign rise = flip && s2;
        assign fall = flip && !s2;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1        <= 1'b0;
                s2        <= 1'b0;
                level_r   <= 1'b0;
                db_cnt    <= '0;
                press_r   <= 1'b0;
                rel_r     <= 1'b0;
                long_r    <= 1'b0;
                rep_r     <= 1'b0;
                state     <= IDLE;
                hold_cnt  <= '0;
                long_done <= 1'b0;
            end else begin
                s1      <= pb_in[i];
                s2      <= s1;
                press_r <= rise;
                rel_r   <= fall;
                long_r  <= 1'b0;
                rep_r   <= 1'b0;

                if (s2 == level_r) begin
                    db_cnt <= '0;
                end else if (flip) begin
                    level_r <= s2;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end

                // Release wins over any long/repeat firing on the same edge.
                if (fall) begin
                    state     <= IDLE;
                    hold_cnt  <= '0;
                    long_done <= 1'b0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (rise) begin
                                state     <= HELD;
                                hold_cnt  <= '0;
                                long_done <= 1'b0;
                            end
                        end
                        HELD: begin
                            if (!long_done) begin
                                if (hold_cnt == LONG_LAST) begin
                                    long_r   <= 1'b1;
                                    hold_cnt <= '0;
                                    if (REPEAT_CYCLES > 0) begin
                                        state <= RPT;
                                    end else begin
                                        long_done <= 1'b1;
                                    end
                                end else begin
                                    hold_cnt <= hold_cnt + 1'b1;
                                end
                            end
                        end
                        RPT: begin
                            if (hold_cnt == RPT_LAST) begin
                                rep_r    <= 1'b1;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                        default: begin
                            state    <= IDLE;
                            hold_cnt <= '0;
                        end
                    endcase
                end
            end
        end

        assign level[i]      = level_r;
        assign press[i]      = press_r;
        assign rel_pulse[i]  = rel_r;
        assign long_press[i] = long_r;
        assign repeat_p[i]   = rep_r;
    end

endmodule
